// File: rtl/rv_bus_pkg.sv
// Shared types for the fetch/loader memory arbiter: master ids, default widths
// and the per-master request bundle.
package rv_bus_pkg;

  typedef enum logic {
    MST_FETCH  = 1'b0,
    MST_LOADER = 1'b1
  } mst_id_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-ported memory.
// The slave modport is the arbiter's view; master is the surrounding SoC side.
interface bus_arbiter_if
  import rv_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              m0_req_i,    m1_req_i;
  logic              m0_we_i,     m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i,   m1_addr_i;
  logic [DATA_W-1:0] m0_wdata_i,  m1_wdata_i;
  logic              m0_gnt_o,    m1_gnt_o;
  logic              m0_rvalid_o, m1_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o,  m1_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
    output m0_rdata_o, m1_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
    input  m0_rdata_o, m1_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker that lets the current owner keep the bus
// for up to MAX_BURST consecutive grants while the other master is waiting.
module rr_pick2
  import rv_bus_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output mst_id_e    gnt_id_o,
  output logic       gnt_valid_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  mst_id_e          last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
  logic             keep_owner;

  // A zero count means nobody owns a burst, so contention goes to the other side.
  always_comb begin
    gnt_valid_o  = |req_i;
    gnt_id_o     = MST_FETCH;
    keep_owner   = (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;

    if (req_i == 2'b10) begin
      gnt_id_o = MST_LOADER;
    end else if (req_i == 2'b11) begin
      gnt_id_o = keep_owner ? last_owner_q : mst_id_e'(~last_owner_q);
    end

    if (gnt_valid_o) begin
      if (gnt_id_o == last_owner_q) begin
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d  = CNT_W'(1);
        last_owner_d = gnt_id_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= MST_LOADER;
      burst_cnt_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between fetch (m0) and loader (m1).
// BUS_ARB_ROUND_ROBIN_EN selects round-robin with burst limit; otherwise m0 has fixed priority.
module bus_arbiter
  import rv_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  logic [1:0]        req;
  logic              pick_valid;
  logic              gnt_valid;
  mst_id_e           gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_pend_q, rd_pend_d;
  mst_id_e           rd_owner_q, rd_owner_d;

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("bus_arbiter: MAX_BURST must be at least 1");
  end

  assign req = {bus.m1_req_i, bus.m0_req_i};

`ifdef BUS_ARB_ROUND_ROBIN_EN
  rr_pick2 #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (pick_valid)
  );
`else
  assign pick_valid = |req;
  assign gnt_id     = bus.m0_req_i ? MST_FETCH : MST_LOADER;
`endif

  // Grants are combinational, so they must be masked while reset is held.
  assign gnt_valid = pick_valid & rst;

  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    if (gnt_valid) begin
      sel_we    = (gnt_id == MST_FETCH) ? bus.m0_we_i    : bus.m1_we_i;
      sel_addr  = (gnt_id == MST_FETCH) ? bus.m0_addr_i  : bus.m1_addr_i;
      sel_wdata = (gnt_id == MST_FETCH) ? bus.m0_wdata_i : bus.m1_wdata_i;
    end
    rd_pend_d  = gnt_valid & ~sel_we;
    rd_owner_d = gnt_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= MST_FETCH;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.m0_gnt_o    = gnt_valid && (gnt_id == MST_FETCH);
  assign bus.m1_gnt_o    = gnt_valid && (gnt_id == MST_LOADER);
  assign bus.mem_req_o   = gnt_valid;
  assign bus.mem_we_o    = sel_we;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_wdata_o = sel_wdata;

  assign bus.m0_rvalid_o = rd_pend_q && (rd_owner_q == MST_FETCH);
  assign bus.m1_rvalid_o = rd_pend_q && (rd_owner_q == MST_LOADER);
  assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.mem_rdata_i : '0;

`ifndef SYNTHESIS
  // Masters must hold a request until it is granted.
  a_m0_hold : assert property (@(posedge clk) disable iff (!rst)
    (bus.m0_req_i && !bus.m0_gnt_o) |=> bus.m0_req_i);
  a_m1_hold : assert property (@(posedge clk) disable iff (!rst)
    (bus.m1_req_i && !bus.m1_gnt_o) |=> bus.m1_req_i);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a small word memory model.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory: untouched words return a fixed pattern, written words their data.
  logic [31:0] wr_mem [0:63];
  logic [63:0] wr_valid;
  logic [5:0]  idx;
  assign idx = bus.mem_addr_o[7:2];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h0:   init_word = 32'h1111_0000;
      32'h4:   init_word = 32'h2222_0004;
      32'h10:  init_word = 32'hDEAD_BEEF;
      default: init_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid        <= '0;
      bus.mem_rdata_i <= '0;
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        wr_mem[idx]   <= bus.mem_wdata_o;
        wr_valid[idx] <= 1'b1;
      end else begin
        bus.mem_rdata_i <= wr_valid[idx] ? wr_mem[idx] : init_word(bus.mem_addr_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0;
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h4;
    @(negedge clk);
    n_checks++; if (bus.m0_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m0_gnt: got %b want 0", bus.m0_gnt_o); end
    n_checks++; if (bus.m1_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m1_gnt: got %b want 0", bus.m1_gnt_o); end
    n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req_o); end
    n_checks++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr_o); end
    n_checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b want 00", {bus.m1_rvalid_o, bus.m0_rvalid_o}); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b01) begin n_fail++; $display("[TB] FAIL release_first_gnt: got %b want 01", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    tick();
    n_checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h1111_0000) begin n_fail++; $display("[TB] FAIL release_m0_read: got v=%b d=%h want v=1 d=11110000", bus.m0_rvalid_o, bus.m0_rdata_o); end
    bus.m0_req_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL release_m1_gnt: got %b want 10", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    tick();
    n_checks++; if (bus.m1_rvalid_o !== 1'b1 || bus.m1_rdata_o !== 32'h2222_0004) begin n_fail++; $display("[TB] FAIL release_m1_read: got v=%b d=%h want v=1 d=22220004", bus.m1_rvalid_o, bus.m1_rdata_o); end
    bus.m1_req_i = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h10;
    @(negedge clk);
    n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL single_gnt: got %b want 10", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    n_checks++; if ({bus.mem_req_o, bus.mem_we_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL single_mem_ctl: got %b want 10", {bus.mem_req_o, bus.mem_we_o}); end
    n_checks++; if (bus.mem_addr_o !== 32'h10) begin n_fail++; $display("[TB] FAIL single_mem_addr: got %h want 10", bus.mem_addr_o); end
    tick();
    bus.m1_req_i = 1'b0;
    n_checks++; if (bus.m1_rvalid_o !== 1'b1 || bus.m1_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL single_m1_read: got v=%b d=%h want v=1 d=deadbeef", bus.m1_rvalid_o, bus.m1_rdata_o); end
    n_checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m0_rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL single_m0_quiet: got v=%b d=%h want v=0 d=0", bus.m0_rvalid_o, bus.m0_rdata_o); end
    tick();
    n_checks++; if (bus.m1_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_rvalid_drop: got %b want 0", bus.m1_rvalid_o); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    applyReset();
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0;
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h4;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp_gnt = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      exp_addr = (exp_gnt == 2'b01) ? 32'h0 : 32'h4;
      n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== exp_gnt) begin n_fail++; $display("[TB] FAIL contention_gnt[%0d]: got %b want %b", i, {bus.m1_gnt_o, bus.m0_gnt_o}, exp_gnt); end
      n_checks++; if (bus.mem_addr_o !== exp_addr) begin n_fail++; $display("[TB] FAIL contention_addr[%0d]: got %h want %h", i, bus.mem_addr_o, exp_addr); end
      tick();
    end
    bus.m0_req_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL contention_tail: got %b want 10", {bus.m1_gnt_o, bus.m0_gnt_o}); end
    tick();
    bus.m1_req_i = 1'b0;
    tick();
  endtask

  task automatic test_interleaved();
    logic        own_m1;
    logic [31:0] exp_data;
    for (int k = 0; k < 6; k++) begin
      own_m1   = k[0];
      exp_data = own_m1 ? 32'h2222_0004 : 32'h1111_0000;
      bus.m0_req_i = ~own_m1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0;
      bus.m1_req_i =  own_m1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h4;
      @(negedge clk);
      n_checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o} !== {own_m1, ~own_m1}) begin n_fail++; $display("[TB] FAIL inter_gnt[%0d]: got %b want %b", k, {bus.m1_gnt_o, bus.m0_gnt_o}, {own_m1, ~own_m1}); end
      tick();
      n_checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== {own_m1, ~own_m1}) begin n_fail++; $display("[TB] FAIL inter_rvalid[%0d]: got %b want %b", k, {bus.m1_rvalid_o, bus.m0_rvalid_o}, {own_m1, ~own_m1}); end
      n_checks++; if ((own_m1 ? bus.m1_rdata_o : bus.m0_rdata_o) !== exp_data) begin n_fail++; $display("[TB] FAIL inter_rdata[%0d]: got %h want %h", k, own_m1 ? bus.m1_rdata_o : bus.m0_rdata_o, exp_data); end
      n_checks++; if ((own_m1 ? bus.m0_rdata_o : bus.m1_rdata_o) !== 32'h0) begin n_fail++; $display("[TB] FAIL inter_other_rdata[%0d]: got %h want 0", k, own_m1 ? bus.m0_rdata_o : bus.m1_rdata_o); end
    end
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 32'h20; bus.m1_wdata_i = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if ({bus.m1_gnt_o, bus.mem_req_o, bus.mem_we_o} !== 3'b111) begin n_fail++; $display("[TB] FAIL write_ctl: got %b want 111", {bus.m1_gnt_o, bus.mem_req_o, bus.mem_we_o}); end
    n_checks++; if (bus.mem_addr_o !== 32'h20) begin n_fail++; $display("[TB] FAIL write_addr: got %h want 20", bus.mem_addr_o); end
    n_checks++; if (bus.mem_wdata_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL write_wdata: got %h want 12345678", bus.mem_wdata_o); end
    tick();
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0;
    n_checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL write_no_rvalid: got %b want 00", {bus.m1_rvalid_o, bus.m0_rvalid_o}); end
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h20;
    @(negedge clk);
    n_checks++; if (bus.m0_gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL readback_gnt: got %b want 1", bus.m0_gnt_o); end
    tick();
    bus.m0_req_i = 1'b0;
    n_checks++; if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL readback_data: got v=%b d=%h want v=1 d=12345678", bus.m0_rvalid_o, bus.m0_rdata_o); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0;
    @(negedge clk);
    n_checks++; if (bus.m0_gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_gnt: got %b want 1", bus.m0_gnt_o); end
    rst = 1'b0;
    #1;
    n_checks++; if ({bus.m0_gnt_o, bus.mem_req_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_forced_gnt: got %b want 00", {bus.m0_gnt_o, bus.mem_req_o}); end
    tick();
    n_checks++; if (bus.m0_rvalid_o !== 1'b0 || bus.m0_rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_rvalid: got v=%b d=%h want v=0 d=0", bus.m0_rvalid_o, bus.m0_rdata_o); end
    bus.m0_req_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.m0_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_after_release: got %b want 0", bus.m0_rvalid_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_interleaved();
    test_write();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
